pdp_mem_arbiter: RTL and testbench

PDP_MEM_ARBITER -- requirements
Module: pdp_mem_arbiter

---
 rtl/pdp_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_pdp_mem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pdp_mem_arbiter.sv
// Two-requester (fetch / write-back) arbiter in front of a single shared memory port.
// Optional fetch starvation guard enabled by defining IF_STARVE_GUARD_EN.
module pdp_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              wb_req,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              wb_gnt,
    output logic              wb_done,
    output logic [DATA_W-1:0] wb_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_IF = 2'd1;
    localparam logic [1:0] S_BUSY_WB = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_gnt_q, if_gnt_d;
    logic              wb_gnt_q, wb_gnt_d;
    logic              if_done_q, if_done_d;
    logic              wb_done_q, wb_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
    logic              busy_q, busy_d;
    logic              pick_if;
    logic              starve_hit;
    logic              arb_now;

    assign arb_now = (state_q == S_IDLE) && (if_req || wb_req);

`ifdef IF_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign starve_hit = (starve_q == CNT_W'(STARVE_LIMIT));

    // Counts wb wins that happened while fetch was waiting; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (arb_now) begin
            if (pick_if || !if_req)
                starve_d = '0;
            else if (!starve_hit)
                starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt_d    = 1'b0;
        wb_gnt_d    = 1'b0;
        if_done_d   = 1'b0;
        wb_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        wb_rdata_d  = wb_rdata_q;
        pick_if     = if_req && (!wb_req || starve_hit);
        case (state_q)
            S_IDLE: begin
                if (arb_now) begin
                    mem_req_d = 1'b1;
                    if (pick_if) begin
                        state_d     = S_BUSY_IF;
                        if_gnt_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end else begin
                        state_d     = S_BUSY_WB;
                        wb_gnt_d    = 1'b1;
                        mem_we_d    = wb_we;
                        mem_addr_d  = wb_addr;
                        mem_wdata_d = wb_wdata;
                    end
                end
            end
            S_BUSY_IF: begin
                if (mem_ack) begin
                    if_rdata_d = mem_rdata;
                    if_done_d  = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_BUSY_WB: begin
                if (mem_ack) begin
                    // Write completions leave the last read data untouched.
                    if (!mem_we_q) wb_rdata_d = mem_rdata;
                    wb_done_d = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_gnt_q    <= 1'b0;
            wb_gnt_q    <= 1'b0;
            if_done_q   <= 1'b0;
            wb_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            wb_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_gnt_q    <= if_gnt_d;
            wb_gnt_q    <= wb_gnt_d;
            if_done_q   <= if_done_d;
            wb_done_q   <= wb_done_d;
            if_rdata_q  <= if_rdata_d;
            wb_rdata_q  <= wb_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_gnt    = if_gnt_q;
    assign wb_gnt    = wb_gnt_q;
    assign if_done   = if_done_q;
    assign wb_done   = wb_done_q;
    assign if_rdata  = if_rdata_q;
    assign wb_rdata  = wb_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Directed bench for pdp_mem_arbiter: vector table of single transactions plus
// hand sequences for starvation, mid-transaction reset and back-to-back reads.
module tb_pdp_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_req, wb_req, wb_we;
    logic [15:0] if_addr, wb_addr, wb_wdata;
    logic        if_gnt, if_done, wb_gnt, wb_done;
    logic [15:0] if_rdata, wb_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;
    logic        man_ack, auto_en;
    logic [15:0] man_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    // Auto responder acks in the first cycle mem_req is seen; data derives from the address.
    assign mem_ack   = man_ack | (auto_en & mem_req);
    assign mem_rdata = auto_en ? (mem_addr + 16'h1000) : man_rdata;

    pdp_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .wb_req(wb_req), .wb_we(wb_we), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
        .wb_gnt(wb_gnt), .wb_done(wb_done), .wb_rdata(wb_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        ifr;
        logic [15:0] ia;
        logic        wbr;
        logic        we;
        logic [15:0] wa;
        logic [15:0] wd;
        int          dly;
        logic [15:0] rd;
        logic        exp_wb;
        logic [15:0] exp_addr;
        logic        exp_we;
        logic [15:0] exp_if_rd;
        logic [15:0] exp_wb_rd;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [15:0] a0, w0;
        logic        we0;
        int          bad, ng, nd, both;
        logic [5:0]  seq, exp_seq;
        int          gcyc[2];
        logic [15:0] rdv[2];

        //        ifr  ia        wbr  we   wa        wd        dly rd        wb   addr      we   if_rd     wb_rd
        tbl[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 16'h1234, 1'b0, 16'h0010, 1'b0, 16'h1234, 16'h0000};
        tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'hBEEF, 5, 16'hDEAD, 1'b1, 16'h0200, 1'b1, 16'h1234, 16'h0000};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000, 1, 16'h5555, 1'b1, 16'h0002, 1'b0, 16'h1234, 16'h5555};
        tbl[3] = '{1'b1, 16'h0040, 1'b1, 1'b0, 16'h0030, 16'h0000, 2, 16'h7777, 1'b1, 16'h0030, 1'b0, 16'h1234, 16'h7777};
        tbl[4] = '{1'b1, 16'h0050, 1'b0, 1'b1, 16'h0099, 16'hFFFF, 1, 16'hA5A5, 1'b0, 16'h0050, 1'b0, 16'hA5A5, 16'h7777};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0060, 16'h1111, 3, 16'h9999, 1'b1, 16'h0060, 1'b1, 16'hA5A5, 16'h7777};

        reset_n = 1'b0; if_req = 0; wb_req = 0; wb_we = 0;
        if_addr = '0; wb_addr = '0; wb_wdata = '0;
        man_ack = 0; auto_en = 0; man_rdata = '0;
        #2;
        chk("reset_ctrl", 32'({mem_req, mem_we, if_gnt, if_done, wb_gnt, wb_done, busy}), 32'h0);
        chk("reset_addr_wdata", {mem_addr, mem_wdata}, 32'h0);
        chk("reset_rdata", {if_rdata, wb_rdata}, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            @(negedge clock);
            if_req = tbl[v].ifr; if_addr = tbl[v].ia;
            wb_req = tbl[v].wbr; wb_we = tbl[v].we; wb_addr = tbl[v].wa; wb_wdata = tbl[v].wd;
            @(negedge clock);
            if_req = 0; wb_req = 0;
            chk($sformatf("v%0d_gnt", v), 32'({if_gnt, wb_gnt}), tbl[v].exp_wb ? 32'h1 : 32'h2);
            chk($sformatf("v%0d_addr", v), 32'(mem_addr), 32'(tbl[v].exp_addr));
            chk($sformatf("v%0d_we", v), 32'({mem_req, mem_we}), 32'({1'b1, tbl[v].exp_we}));
            if (tbl[v].exp_we) chk($sformatf("v%0d_wdata", v), 32'(mem_wdata), 32'(tbl[v].wd));
            a0 = mem_addr; w0 = mem_wdata; we0 = mem_we; bad = 0;
            for (int i = 1; i < tbl[v].dly; i++) begin
                @(negedge clock);
                if (!mem_req || mem_addr !== a0 || mem_wdata !== w0 || mem_we !== we0 || if_done || wb_done)
                    bad++;
            end
            chk($sformatf("v%0d_stable", v), 32'(bad), 32'h0);
            man_ack = 1; man_rdata = tbl[v].rd;
            @(negedge clock);
            man_ack = 0;
            chk($sformatf("v%0d_done", v), 32'({if_done, wb_done, mem_req}), tbl[v].exp_wb ? 32'h2 : 32'h4);
            chk($sformatf("v%0d_rdata", v), {if_rdata, wb_rdata}, {tbl[v].exp_if_rd, tbl[v].exp_wb_rd});
            @(negedge clock);
            chk($sformatf("v%0d_idle", v), 32'({busy, if_done, wb_done}), 32'h0);
        end

        // Both requesters held high continuously.
        auto_en = 1; wb_we = 0; wb_addr = 16'h0100; if_addr = 16'h0110;
        if_req = 1; wb_req = 1;
        ng = 0; both = 0; seq = '0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            @(negedge clock);
            if ((if_gnt && wb_gnt) || (if_done && wb_done)) both++;
            if (if_gnt) begin seq[ng] = 1'b1; ng++; end
            else if (wb_gnt) ng++;
        end
        if_req = 0; wb_req = 0;
`ifdef IF_STARVE_GUARD_EN
        exp_seq = 6'b010000;
`else
        exp_seq = 6'b000000;
`endif
        chk("starve_grants", 32'(ng), 32'd6);
        chk("starve_order", 32'(seq), 32'(exp_seq));
        chk("starve_exclusive", 32'(both), 32'h0);
        for (int c = 0; c < 10 && busy; c++) @(negedge clock);
        chk("starve_drain", 32'(busy), 32'h0);
        auto_en = 0;

        // Reset during an outstanding write, then a late ack.
        @(negedge clock);
        wb_req = 1; wb_we = 1; wb_addr = 16'h0300; wb_wdata = 16'h4444;
        @(negedge clock);
        wb_req = 0;
        chk("rst_mid_gnt", 32'({wb_gnt, mem_req}), 32'h3);
        @(negedge clock);
        #2 reset_n = 0;
        #1 chk("rst_async", 32'({mem_req, busy, wb_done, mem_we}), 32'h0);
        chk("rst_rdata", {if_rdata, wb_rdata}, 32'h0);
        @(negedge clock);
        reset_n = 1; man_ack = 1; bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (c == 1) man_ack = 0;
            if (wb_done || if_done || mem_req || busy) bad++;
        end
        chk("rst_late_ack", 32'(bad), 32'h0);

        // Spurious ack in IDLE, then back-to-back wb reads.
        man_ack = 1; bad = 0;
        repeat (2) begin
            @(negedge clock);
            if (wb_done || if_done || busy || wb_gnt || if_gnt) bad++;
        end
        man_ack = 0;
        chk("spurious_ack", 32'(bad), 32'h0);
        auto_en = 1; wb_we = 0; wb_addr = 16'h0002; wb_req = 1;
        ng = 0; nd = 0;
        for (int c = 0; c < 30 && nd < 2; c++) begin
            @(negedge clock);
            if (wb_gnt && ng < 2) begin
                gcyc[ng] = c; ng++;
                if (ng == 1) wb_addr = 16'h0004;
                else wb_req = 0;
            end
            if (wb_done && nd < 2) begin rdv[nd] = wb_rdata; nd++; end
        end
        wb_req = 0;
        chk("b2b_counts", 32'({ng[7:0], nd[7:0]}), 32'h0202);
        chk("b2b_spacing", 32'(gcyc[1] - gcyc[0]), 32'd3);
        chk("b2b_rdata", {rdv[0], rdv[1]}, 32'h10021004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
